item_stock_counter: RTL and testbench
=====================================

Name: item_stock_counter

Overview:
- Per-slot inventory register bank for the vending machine; sits directly upstream of the 8-to-1 item-count display multiplexer.
- Holds eight 4-bit stock counts and drives them in parallel as Cnt0..Cnt7, which feed the multiplexer data inputs W0..W7.
- Handles vend requests (check stock, decrement, pulse dispense) and restock requests for the slot chosen by the same 3-bit select that drives the multiplexer.

Parameters:
- INIT_COUNT, 4'd5, stock value loaded into every slot on reset.
- DISP_CYCLES, 4, number of cycles Dispense is held high per successful vend (range 1..15).
- LOW_THRESH, 4'd2, low-stock threshold; used only with the optional feature.

Ports:
- Clock  input  1  system clock, rising-edge.
- Resetn  input  1  asynchronous, active-low reset.
- Sel  input  3  slot select, {S2,S1,S0}; slot 0..7.
- Vend  input  1  vend request, level (debounced button).
- Restock  input  1  restock request, level (debounced button).
- RestockQty  input  4  units to add on restock.
- Cnt0..Cnt7  output  4 each  current stock of slots 0..7.
- Dispense  output  1  dispense motor enable.
- VendFail  output  1  one-cycle pulse: vend refused because the slot is empty.
- Busy  output  1  high whenever the FSM is not in IDLE.
- SoldOut  output  1  combinational; high when the count of the currently selected slot is 0.

Behaviour:
- Reset: clocked logic is forced while Resetn=0 and is independent of Clock.
  - All counts = INIT_COUNT.
  - Dispense=0, VendFail=0, Busy=0.
  - FSM = IDLE; edge-detect registers = 0.
- Edge detection: Vend and Restock are registered once. A request is a rising edge: current=1 and previous=0. Holding a level produces no repeat requests.
- FSM states: IDLE, CHECK, DISPENSE, RELEASE.
- IDLE:
  - On a vend edge: latch Sel into slot register SL, go to CHECK.
  - Else on a restock edge: count[Sel] = min(count[Sel] + RestockQty, 15). Use 5-bit intermediate arithmetic so the result saturates at 15 and never wraps. Stay in IDLE.
  - Vend and restock edges in the same cycle: vend wins; the restock edge is discarded.
- CHECK (1 cycle):
  - count[SL] == 0: pulse VendFail for this one cycle, go to RELEASE.
  - Else: count[SL] decrements by 1 at the end of this cycle. Load the dispense timer with DISP_CYCLES, go to DISPENSE.
- DISPENSE:
  - Dispense=1 for exactly DISP_CYCLES consecutive cycles, starting the cycle after CHECK.
  - Then go to RELEASE.
- RELEASE: wait until registered Vend = 0, then go to IDLE.
- Latency: vend edge detected at cycle N → CHECK at N+1 → Dispense high from N+2 for DISP_CYCLES cycles.
- Decrement latency: count visible on CntX at N+2.
- Request handling while Busy: restock edges are ignored (no queuing). Sel changes while Busy do not affect SL.
- Resetn asserted mid-operation: immediate return to IDLE, counts restored to INIT_COUNT, Dispense drops immediately.
- A count never underflows below 0 and never exceeds 15.

Optional Feature:
- Macro: ITEM_STOCK_LOW_ALARM_EN.
- Defined:
  - Adds output LowStock (1 bit), registered.
  - LowStock is high when the count of the currently selected slot is greater than 0 and ≤ LOW_THRESH.
  - It updates one cycle after a change in Sel or the count; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset → all Cnt = 5, Dispense = 0, Busy = 0. Assert Resetn low mid-DISPENSE → Dispense drops without a clock edge and counts return to 5.
- Sel=3, pulse Vend → Cnt3 goes 5→4. Dispense high for exactly 4 cycles starting 2 cycles after the edge is detected. Other slots unchanged.
- Drain slot 0 to 0, then vend again → VendFail is a one-cycle pulse, no Dispense, Cnt0 stays 0, SoldOut=1 while Sel=0.
- Sel=7 with Cnt7=12, RestockQty=6, pulse Restock → Cnt7 = 15 (saturated). Restock of 0 → no change.
- Vend and Restock rising in the same cycle with Sel=2 → only the vend happens (Cnt2 −1). A restock edge during DISPENSE is ignored.
- Hold Vend high through DISPENSE → exactly one decrement, and the FSM stays in RELEASE until Vend falls. With ITEM_STOCK_LOW_ALARM_EN defined and Cnt=3 → 2, LowStock rises one cycle later.

Source files
------------

// File: rtl/item_stock_counter.sv
// Eight-slot vending stock bank with vend/restock request FSM and dispense timer.
// Optional registered LowStock output is enabled by defining ITEM_STOCK_LOW_ALARM_EN.
module item_stock_counter #(
  parameter logic [3:0] INIT_COUNT  = 4'd5,
  parameter int         DISP_CYCLES = 4,
  parameter logic [3:0] LOW_THRESH  = 4'd2
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [2:0] Sel,
  input  logic       Vend,
  input  logic       Restock,
  input  logic [3:0] RestockQty,
  output logic [3:0] Cnt0,
  output logic [3:0] Cnt1,
  output logic [3:0] Cnt2,
  output logic [3:0] Cnt3,
  output logic [3:0] Cnt4,
  output logic [3:0] Cnt5,
  output logic [3:0] Cnt6,
  output logic [3:0] Cnt7,
  output logic       Dispense,
  output logic       VendFail,
  output logic       Busy,
`ifdef ITEM_STOCK_LOW_ALARM_EN
  output logic       LowStock,
`endif
  output logic       SoldOut
);

  // state    | meaning
  // IDLE     | waiting for a vend or restock request
  // CHECK    | one cycle: test stock of latched slot, decrement or refuse
  // DISPENSE | motor enabled for DISP_CYCLES cycles
  // RELEASE  | wait for the vend button to be let go
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    DISPENSE = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt [8];
  logic [2:0]  slot;
  logic [3:0]  timer;
  logic        vend_r, restock_r;
  logic        vend_edge, restock_edge;
  logic        do_restock, do_dec, load_slot;
  logic [4:0]  restock_sum;
  logic [3:0]  restock_sat;

  assign vend_edge    = Vend & ~vend_r;
  assign restock_edge = Restock & ~restock_r;

  // 5-bit sum so an overflow past 15 saturates instead of wrapping
  assign restock_sum = {1'b0, cnt[Sel]} + {1'b0, RestockQty};
  assign restock_sat = restock_sum[4] ? 4'hF : restock_sum[3:0];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      vend_r    <= 1'b0;
      restock_r <= 1'b0;
    end else begin
      state     <= state_next;
      vend_r    <= Vend;
      restock_r <= Restock;
    end
  end

  always_comb begin
    state_next = state;
    do_restock = 1'b0;
    do_dec     = 1'b0;
    load_slot  = 1'b0;
    VendFail   = 1'b0;
    case (state)
      IDLE: begin
        if (vend_edge) begin
          load_slot  = 1'b1;
          state_next = CHECK;
        end else if (restock_edge) begin
          do_restock = 1'b1;
        end
      end
      CHECK: begin
        if (cnt[slot] == 4'd0) begin
          VendFail   = 1'b1;
          state_next = RELEASE;
        end else begin
          do_dec     = 1'b1;
          state_next = DISPENSE;
        end
      end
      DISPENSE: begin
        if (timer <= 4'd1) state_next = RELEASE;
      end
      RELEASE: begin
        if (!vend_r) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      slot  <= 3'd0;
      timer <= 4'd0;
    end else begin
      if (load_slot) slot <= Sel;
      if (state == CHECK) timer <= 4'(DISP_CYCLES);
      else if (state == DISPENSE) timer <= timer - 4'd1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 8; i++) cnt[i] <= INIT_COUNT;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (do_restock && (Sel == 3'(i))) cnt[i] <= restock_sat;
        else if (do_dec && (slot == 3'(i))) cnt[i] <= cnt[i] - 4'd1;
      end
    end
  end

  assign Dispense = (state == DISPENSE);
  assign Busy     = (state != IDLE);
  assign SoldOut  = (cnt[Sel] == 4'd0);

  assign Cnt0 = cnt[0];
  assign Cnt1 = cnt[1];
  assign Cnt2 = cnt[2];
  assign Cnt3 = cnt[3];
  assign Cnt4 = cnt[4];
  assign Cnt5 = cnt[5];
  assign Cnt6 = cnt[6];
  assign Cnt7 = cnt[7];

`ifdef ITEM_STOCK_LOW_ALARM_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) LowStock <= 1'b0;
    else         LowStock <= (cnt[Sel] != 4'd0) && (cnt[Sel] <= LOW_THRESH);
  end
`else
  logic unused_low_thresh;
  assign unused_low_thresh = ^LOW_THRESH;
`endif

endmodule

// File: tb/tb_item_stock_counter.sv
// Directed self-checking bench for item_stock_counter (default parameters).
// Covers reset, vend timing, empty-slot refusal, restock saturation and priorities.
module tb_item_stock_counter;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [2:0] Sel;
  logic       Vend, Restock;
  logic [3:0] RestockQty;
  logic [3:0] Cnt0, Cnt1, Cnt2, Cnt3, Cnt4, Cnt5, Cnt6, Cnt7;
  logic       Dispense, VendFail, Busy, SoldOut;
`ifdef ITEM_STOCK_LOW_ALARM_EN
  logic       LowStock;
`endif

  int total = 0;
  int bad   = 0;
  int ncyc;

  item_stock_counter dut (
    .Clock(Clock), .Resetn(Resetn), .Sel(Sel), .Vend(Vend), .Restock(Restock),
    .RestockQty(RestockQty),
    .Cnt0(Cnt0), .Cnt1(Cnt1), .Cnt2(Cnt2), .Cnt3(Cnt3),
    .Cnt4(Cnt4), .Cnt5(Cnt5), .Cnt6(Cnt6), .Cnt7(Cnt7),
    .Dispense(Dispense), .VendFail(VendFail), .Busy(Busy),
`ifdef ITEM_STOCK_LOW_ALARM_EN
    .LowStock(LowStock),
`endif
    .SoldOut(SoldOut)
  );

  always #5 Clock = ~Clock;

  function automatic logic [3:0] cnt_of(input int i);
    case (i)
      0: return Cnt0;  1: return Cnt1;  2: return Cnt2;  3: return Cnt3;
      4: return Cnt4;  5: return Cnt5;  6: return Cnt6;  default: return Cnt7;
    endcase
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full successful vend on slot s with a short button press; returns dispense length.
  task automatic vend_once(input logic [2:0] s, output int n);
    Sel = s; Vend = 1'b1;
    tick();
    Vend = 1'b0;
    tick();
    n = 0;
    for (int k = 0; k < 20 && Dispense; k++) begin
      n++;
      tick();
    end
    tick();
  endtask

  initial begin
    Resetn = 1'b0; Sel = 3'd0; Vend = 1'b0; Restock = 1'b0; RestockQty = 4'd0;
    #12;
    for (int i = 0; i < 8; i++) check($sformatf("reset_cnt%0d", i), 8'(cnt_of(i)), 8'd5);
    check("reset_dispense", 8'(Dispense), 8'd0);
    check("reset_busy", 8'(Busy), 8'd0);
    check("reset_vendfail", 8'(VendFail), 8'd0);
    Resetn = 1'b1;
    tick(); tick();

    // Vend slot 3: CHECK one cycle after the edge, dispense from the next
    Sel = 3'd3; Vend = 1'b1;
    tick();
    check("v3_check_busy", 8'(Busy), 8'd1);
    check("v3_check_disp", 8'(Dispense), 8'd0);
    check("v3_check_cnt", 8'(Cnt3), 8'd5);
    Vend = 1'b0;
    tick();
    check("v3_disp_start", 8'(Dispense), 8'd1);
    check("v3_cnt_dec", 8'(Cnt3), 8'd4);
    ncyc = 0;
    for (int k = 0; k < 20 && Dispense; k++) begin
      ncyc++;
      tick();
    end
    check("v3_disp_len", 8'(ncyc), 8'd4);
    check("v3_release_busy", 8'(Busy), 8'd1);
    tick();
    check("v3_idle", 8'(Busy), 8'd0);
    for (int i = 0; i < 8; i++)
      if (i != 3) check($sformatf("v3_other_cnt%0d", i), 8'(cnt_of(i)), 8'd5);

    // Drain slot 0, then vend an empty slot
    for (int j = 0; j < 5; j++) vend_once(3'd0, ncyc);
    check("drain_cnt0", 8'(Cnt0), 8'd0);
    check("drain_soldout", 8'(SoldOut), 8'd1);
    Sel = 3'd0; Vend = 1'b1;
    tick();
    check("empty_vendfail", 8'(VendFail), 8'd1);
    check("empty_disp", 8'(Dispense), 8'd0);
    Vend = 1'b0;
    tick();
    check("empty_vendfail_pulse", 8'(VendFail), 8'd0);
    check("empty_no_disp", 8'(Dispense), 8'd0);
    tick();
    check("empty_idle", 8'(Busy), 8'd0);
    check("empty_cnt0", 8'(Cnt0), 8'd0);
    Sel = 3'd1;
    #1;
    check("soldout_sel1", 8'(SoldOut), 8'd0);

    // Restock slot 7 to 12, then saturate at 15, then add 0
    Sel = 3'd7; RestockQty = 4'd7; Restock = 1'b1;
    tick();
    check("rs7_to12", 8'(Cnt7), 8'd12);
    Restock = 1'b0;
    tick();
    RestockQty = 4'd6; Restock = 1'b1;
    tick();
    check("rs7_sat", 8'(Cnt7), 8'd15);
    Restock = 1'b0;
    tick();
    RestockQty = 4'd0; Restock = 1'b1;
    tick();
    check("rs7_zero", 8'(Cnt7), 8'd15);
    Restock = 1'b0;
    tick();
    Sel = 3'd6; Restock = 1'b1;
    tick();
    check("rs6_zero", 8'(Cnt6), 8'd5);
    Restock = 1'b0;
    RestockQty = 4'd3;
    tick();
    check("rs_level_hold", 8'(Cnt6), 8'd5);

    // Vend and restock on the same cycle: vend wins; restock during dispense ignored
    Sel = 3'd2; Vend = 1'b1; Restock = 1'b1;
    tick();
    check("both_check_cnt", 8'(Cnt2), 8'd5);
    Vend = 1'b0; Restock = 1'b0;
    tick();
    check("both_dec", 8'(Cnt2), 8'd4);
    Restock = 1'b1;
    tick();
    Restock = 1'b0;
    for (int k = 0; k < 20 && Busy; k++) tick();
    check("rs_busy_ignored", 8'(Cnt2), 8'd4);
    check("rs_busy_idle", 8'(Busy), 8'd0);

    // Hold Vend through dispense: one decrement, park in RELEASE
    Sel = 3'd4; Vend = 1'b1;
    tick(); tick();
    for (int k = 0; k < 20 && Dispense; k++) tick();
    tick(); tick(); tick();
    check("hold_release", 8'(Busy), 8'd1);
    check("hold_one_dec", 8'(Cnt4), 8'd4);
    Vend = 1'b0;
    tick();
    check("hold_release2", 8'(Busy), 8'd1);
    tick();
    check("hold_idle", 8'(Busy), 8'd0);
    tick();
    check("hold_no_repeat", 8'(Cnt4), 8'd4);

`ifdef ITEM_STOCK_LOW_ALARM_EN
    vend_once(3'd1, ncyc);
    vend_once(3'd1, ncyc);
    check("low_at3", 8'(LowStock), 8'd0);
    Sel = 3'd1; Vend = 1'b1;
    tick();
    Vend = 1'b0;
    tick();
    check("low_cnt2", 8'(Cnt1), 8'd2);
    check("low_not_yet", 8'(LowStock), 8'd0);
    tick();
    check("low_rise", 8'(LowStock), 8'd1);
    for (int k = 0; k < 20 && Busy; k++) tick();
`endif

    // Reset mid-dispense: asynchronous drop and count restore
    Sel = 3'd5; Vend = 1'b1;
    tick();
    Vend = 1'b0;
    tick();
    check("mid_disp", 8'(Dispense), 8'd1);
    check("mid_cnt5", 8'(Cnt5), 8'd4);
    #2 Resetn = 1'b0;
    #1;
    check("rst_async_disp", 8'(Dispense), 8'd0);
    check("rst_async_cnt5", 8'(Cnt5), 8'd5);
    check("rst_async_cnt7", 8'(Cnt7), 8'd5);
    check("rst_async_busy", 8'(Busy), 8'd0);
    #2 Resetn = 1'b1;
    tick();
    check("post_rst_idle", 8'(Busy), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
